// File: rtl/add512_limb_seq_if.sv
// add512_limb_seq_if: bundles the request, adder-stage and response signals
// of the 512-bit limb-sequenced adder.
//   request  : in_valid/in_ready handshake, in_a, in_b, in_cin
//   adder    : add_en, add_a, add_b out to the 64-bit registered adder stage;
//              add_res back from its output register
//   response : out_valid/out_ready handshake, out_sum, out_cout
// Modports: slave = the sequencer itself, master = whatever sits around it
// (feeder, adder stage and consumer).
interface add512_limb_seq_if #(
  parameter int LIMB_W = 64,
  parameter int LIMBS  = 8
) ();
  localparam int W = LIMB_W * LIMBS;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic              in_cin;
  logic              add_en;
  logic [LIMB_W-1:0] add_a;
  logic [LIMB_W-1:0] add_b;
  logic [LIMB_W-1:0] add_res;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_sum;
  logic              out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_res, out_ready,
    output in_ready, add_en, add_a, add_b, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, add_res, out_ready,
    input  in_ready, add_en, add_a, add_b, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/add512_limb_seq.sv
// add512_limb_seq: computes A+B+cin on LIMBS*LIMB_W-bit operands by streaming
// limb pairs through an external registered LIMB_W-bit adder (carry-in tied 0,
// no carry out) and rippling the inter-limb carry here.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - add512_limb_seq_if.slave (request, adder-stage and response groups)
// Timing: ISSUE presents limb k in cycle t0+k (t0..t0+LIMBS-1) plus one flush
// cycle; the adder's result for limb k shows up on add_res in cycle t0+k+2,
// so collection trails issue by two cycles and finishes in DRAIN.
module add512_limb_seq #(
  parameter int LIMB_W = 64,
  parameter int LIMBS  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  add512_limb_seq_if.slave  bus
);
  localparam int W = LIMB_W * LIMBS;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d, col_cnt_q, col_cnt_d;
  // vld_pipe_q[0]: a real limb was issued last cycle; [1]: two cycles ago,
  // i.e. add_res carries a limb sum this cycle.
  logic [1:0]        vld_pipe_q, vld_pipe_d;

  logic [LIMB_W-1:0] iss_a, iss_b, s, sum_j;
  logic              a_msb, b_msb, g, carry_next, issue_limb, collect;

  // Limb selection for issue and for the collect-side carry recovery.
  always_comb begin
    iss_a = '0;
    iss_b = '0;
    a_msb = 1'b0;
    b_msb = 1'b0;
    for (int k = 0; k < LIMBS; k++) begin
      if (state_q == ISSUE && iss_cnt_q == CNT_W'(k)) begin
        iss_a = a_q[k*LIMB_W +: LIMB_W];
        iss_b = b_q[k*LIMB_W +: LIMB_W];
      end
      if (col_cnt_q == CNT_W'(k)) begin
        a_msb = a_q[k*LIMB_W + LIMB_W-1];
        b_msb = b_q[k*LIMB_W + LIMB_W-1];
      end
    end
  end

  assign issue_limb = (state_q == ISSUE) && (iss_cnt_q < CNT_W'(LIMBS));
  assign collect    = vld_pipe_q[1];

  // The adder drops its carry out; rebuild it from the operand MSBs and the
  // result MSB, then fold in the running carry.
  assign s          = bus.add_res;
  assign g          = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s[LIMB_W-1]);
  assign sum_j      = s + {{(LIMB_W-1){1'b0}}, carry_q};
  assign carry_next = g | (carry_q & (&s));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    iss_cnt_d  = iss_cnt_q;
    col_cnt_d  = col_cnt_q;
    vld_pipe_d = {vld_pipe_q[0], issue_limb};

    if (collect) begin
      for (int k = 0; k < LIMBS; k++)
        if (col_cnt_q == CNT_W'(k)) sum_d[k*LIMB_W +: LIMB_W] = sum_j;
      carry_d   = carry_next;
      col_cnt_d = col_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d       = bus.in_a;
          b_d       = bus.in_b;
          carry_d   = bus.in_cin;
          iss_cnt_d = '0;
          col_cnt_d = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        iss_cnt_d = iss_cnt_q + 1'b1;
        // Count LIMBS is the flush cycle: zero operands, enable still high
        // so the last limb reaches the adder output register.
        if (iss_cnt_q == CNT_W'(LIMBS)) state_d = DRAIN;
      end
      DRAIN: begin
        cout_d  = carry_next;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      iss_cnt_q  <= '0;
      col_cnt_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cout_q     <= cout_d;
      iss_cnt_q  <= iss_cnt_d;
      col_cnt_q  <= col_cnt_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Outputs decode straight from state so add_en falls with async reset.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.add_en    = (state_q == ISSUE);
  assign bus.add_a     = iss_a;
  assign bus.add_b     = iss_b;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_add512_limb_seq.sv
module tb_add512_limb_seq;
  localparam int LW = 64;
  localparam int NL = 8;
  localparam int W  = LW * NL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add512_limb_seq_if #(.LIMB_W(LW), .LIMBS(NL)) bus ();

  add512_limb_seq #(.LIMB_W(LW), .LIMBS(NL), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered adder stage: input regs and output reg, all gated by add_en.
  logic [LW-1:0] ra, rb, rres;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0; rb <= '0; rres <= '0;
    end else if (bus.add_en) begin
      ra   <= bus.add_a;
      rb   <= bus.add_b;
      rres <= ra + rb;
    end
  end
  assign bus.add_res = rres;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand512();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One request end to end; hold>0 keeps out_ready low that many cycles in DONE.
  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input int hold, input string tag);
    logic [W:0]    exp;
    logic [W-1:0]  held;
    logic [LW-1:0] a0, b0;
    int            cyc, en_cnt;
    logic          seen, stable;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = ci;
    bus.out_ready = (hold == 0);
    cyc = 0; en_cnt = 0; seen = 1'b0; a0 = '0; b0 = '0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.in_valid = 1'b0;
        a0 = bus.add_a;
        b0 = bus.add_b;
      end
      cyc++;
      if (bus.add_en) en_cnt++;
      if (bus.out_valid) seen = 1'b1;
    end
    check({tag, " out_valid seen"}, seen, 1);
    check({tag, " latency"}, cyc, 11);
    check({tag, " add_en cycles"}, en_cnt, 9);
    check({tag, " limb0 a"}, a0, a[LW-1:0]);
    check({tag, " limb0 b"}, b0, b[LW-1:0]);
    check({tag, " sum"}, {bus.out_cout, bus.out_sum}, exp);
    check({tag, " in_ready busy"}, bus.in_ready, 0);
    if (hold > 0) begin
      held = bus.out_sum;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.out_valid || bus.in_ready || bus.out_sum !== held) stable = 1'b0;
      end
      check({tag, " hold stable"}, stable, 1);
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, " out_valid drop"}, bus.out_valid, 0);
    check({tag, " back to idle"}, bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic          ok;
    logic [W-1:0]  ones, a, b;
    ones = '1;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst add_en", bus.add_en, 0);
    check("rst add_a", bus.add_a, 0);
    check("rst out_sum", {bus.out_cout, bus.out_sum}, 0);
    @(negedge clk); rst = 1'b0;

    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!bus.in_ready || bus.out_valid || bus.add_en || bus.out_sum !== '0) ok = 1'b0;
    end
    check("idle 20 cycles", ok, 1);

    run_req(512'd1, 512'd2, 1'b0, 0, "1+2");
    run_req({{(W-LW){1'b0}}, {LW{1'b1}}}, 512'd1, 1'b0, 0, "limb carry");
    run_req(ones, '0, 1'b1, 0, "ripple all");
    run_req(ones, ones, 1'b1, 0, "max+max+1");
    run_req(rand512(), rand512(), 1'b1, 5, "backpressure");

    // Abort in cycle t0+4 of ISSUE.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = rand512(); bus.in_b = rand512(); bus.in_cin = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort add_en", bus.add_en, 0);
    check("abort in_ready", bus.in_ready, 1);
    check("abort out_sum", {bus.out_cout, bus.out_sum}, 0);
    @(negedge clk); rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid || bus.add_en) ok = 1'b0;
    end
    check("abort no out_valid", ok, 1);
    run_req(512'd5, 512'd7, 1'b0, 0, "5+7");

    for (int i = 0; i < 6; i++) begin
      a = rand512();
      b = rand512();
      // Force all-ones limbs on some runs to exercise the ripple term.
      if (i % 2 == 1) begin
        for (int k = 0; k < NL; k++)
          if ($urandom_range(0, 1) == 1) begin
            a[k*LW +: LW] = {LW{1'b1}};
            b[k*LW +: LW] = '0;
          end
      end
      run_req(a, b, 1'($urandom_range(0, 1)), 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add512_limb_seq.md
Name: add512_limb_seq

Overview:
- Upstream feeder and downstream collector for the registered 64-bit CLA adder stage (input regs, enable, output reg; Ci tied 0, no carry out).
- Accepts one 512-bit A+B+cin request by valid/ready handshake.
- Streams 64-bit limb pairs into the adder stage, collects the limb sums, and applies carry ripple between limbs itself.
- Returns a 512-bit sum plus carry out. It is the wide-add front end of the MAC_512 datapath.

Parameters:
- LIMB_W, 64, width of one limb; must match the adder stage.
- LIMBS, 8, number of limbs; operand width = LIMB_W*LIMBS.
- CNT_W, 4, limb counter width; must satisfy 2^CNT_W > LIMBS+1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_a  in  512  operand A.
- in_b  in  512  operand B.
- in_cin  in  1  carry into limb 0.
- add_en  out  1  enable to adder stage.
- add_a  out  64  limb of A to adder stage.
- add_b  out  64  limb of B to adder stage.
- add_res  in  64  registered limb sum from adder stage (A_reg+B_reg, carry-in 0).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_sum  out  512  A+B+cin mod 2^512.
- out_cout  out  1  carry out of bit 511.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; in_ready=1; out_valid=0; add_en=0; add_a=add_b=0; out_sum=0; out_cout=0.
  - Counters and internal carry cleared.
- Adder-stage contract: the adder output register only updates while add_en=1. Limb k presented in cycle t becomes visible on add_res in cycle t+2 only if add_en=1 in both t and t+1.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: latch in_a, in_b, in_cin; issue counter=0; carry=in_cin; go ISSUE.
  - ISSUE: lasts LIMBS+1 cycles (t0..t0+LIMBS).
    - add_en=1 throughout.
    - For cycles t0+k, k<LIMBS: add_a=A[k*64+:64], add_b=B[k*64+:64].
    - In cycle t0+LIMBS: add_a=add_b=0 (flush cycle only pushes limb LIMBS-1 into the output register).
    - Then go DRAIN.
  - Collection: runs in cycles t0+2 .. t0+LIMBS+1 and overlaps ISSUE/DRAIN. A collect counter j selects limb j in cycle t0+j+2.
    - s = add_res; a63, b63 = bit 63 of latched limb j.
    - g = (a63&b63) | ((a63^b63)&~s[63]) (carry of the raw limb add).
    - sum_j = s + carry (64-bit wrap); carry_next = g | (carry & (s==64'hFFFF_FFFF_FFFF_FFFF)).
    - Write sum_j into out_sum[j*64+:64]; carry <= carry_next.
  - DRAIN: one cycle (t0+LIMBS+1), add_en=0. Collects the last limb; out_cout <= final carry_next; go DONE.
  - DONE:
    - out_valid=1; out_sum/out_cout stable.
    - On out_ready: out_valid=0 next cycle, go IDLE.
    - Without out_ready, hold indefinitely.
- Latency: accept edge to out_valid = LIMBS+3 cycles (11 at default).
- Throughput: one request per LIMBS+4 cycles minimum (IDLE cycle required between requests; no overlap).
- in_ready=0 in ISSUE, DRAIN and DONE; in_valid there is ignored and the request is not dropped (upstream holds it).
- add_en is never high outside ISSUE. add_a/add_b are 0 outside ISSUE.
- out_sum contents are undefined to consumers except while out_valid=1. Implementation clears them only on reset.
- Reset mid-operation (any state): abort immediately to reset values. add_en drops asynchronously. Any partial result is discarded; no out_valid is produced for the aborted request.
- out_ready while not DONE: ignored.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, add_en=0, out_sum=0; hold 20 cycles with in_valid=0 -> no change.
- A=1, B=2, cin=0, out_ready=1 -> add_en high exactly 9 cycles, limb0 issued add_a=1, add_b=2; out_valid in cycle 11 after accept; out_sum=3, out_cout=0.
- A=2^64-1 (limb0 all ones), B=1, cin=0 -> limb0 sum 0 with g=1; limb1 result 1; out_sum=2^64, out_cout=0 (cross-limb carry).
- A=2^512-1, B=0, cin=1 -> every add_res=all ones; carry ripples via the s==all-ones term; out_sum=0, out_cout=1.
- A=B=2^512-1, cin=1 -> out_sum=2^512-1, out_cout=1.
- Back-pressure/reset: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stable, in_ready=0; then pulse out_ready -> IDLE. Separately, assert rst in cycle t0+4 of ISSUE -> add_en=0 immediately, no out_valid ever; next request A=5, B=7 -> out_sum=12.
